// File: rtl/store_data_align.sv
// store_data_align: turns sw/sh/sb store requests into word-wide memory writes.
// Default build: sub-word stores use read-modify-write (READ -> MERGE -> WRITE)
// because the memory has no byte enables.
// Optional macro STORE_BE_EN: adds mem_be, so sub-word stores write directly
// with the data pre-shifted into its lane. mem_rd_en then stays low.
module store_data_align #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              st_valid,
   output logic              st_ready,
   input  logic [ADDR_W-1:0] st_addr,
   input  logic [31:0]       st_data,
   input  logic [1:0]        st_type,
   output logic              st_done,
   output logic              st_err,
   output logic [ADDR_W-3:0] mem_addr,
   output logic              mem_rd_en,
   input  logic [31:0]       mem_rd_data,
   output logic              mem_wr_en,
`ifdef STORE_BE_EN
   output logic [3:0]        mem_be,
`endif
   output logic [31:0]       mem_wr_data
);

   typedef enum logic [2:0] {IDLE, READ, MERGE, WRITE, ERR} state_e;

   state_e            state_q, state_d;
   logic              accept, req_err;
   logic [ADDR_W-3:0] addr_q;
   logic [31:0]       wdata_q;

   assign accept = st_valid && (state_q == IDLE);

   // Alignment / encoding checks; byte stores can never be misaligned
   always_comb begin
      req_err = 1'b0;
      case (st_type)
         2'd0:    req_err = (st_addr[1:0] != 2'b00);
         2'd1:    req_err = st_addr[0];
         2'd3:    req_err = 1'b1;
         default: req_err = 1'b0;
      endcase
   end

   // State register; reset aborts any in-flight store without a write or done
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (accept) begin
`ifdef STORE_BE_EN
            state_d = req_err ? ERR : WRITE;
`else
            state_d = req_err ? ERR : ((st_type == 2'd0) ? WRITE : READ);
`endif
         end
         READ:    state_d = MERGE;
         MERGE:   state_d = WRITE;
         WRITE:   state_d = IDLE;
         ERR:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

`ifdef STORE_BE_EN
   logic [3:0]  be_q, be_d;
   logic [31:0] lane_data_d;
   logic        unused_rd;

   assign unused_rd = ^mem_rd_data;

   // Place sub-word data into its little-endian lane and build the byte mask
   always_comb begin
      lane_data_d = st_data;
      be_d        = 4'b1111;
      case (st_type)
         2'd1: begin
            lane_data_d = st_addr[1] ? {st_data[15:0], 16'h0000} : {16'h0000, st_data[15:0]};
            be_d        = st_addr[1] ? 4'b1100 : 4'b0011;
         end
         2'd2: begin
            lane_data_d = {24'h000000, st_data[7:0]} << {st_addr[1:0], 3'b000};
            be_d        = 4'b0001 << st_addr[1:0];
         end
         default: ;
      endcase
   end

   // Latch word address, lane data and byte enables on a good request
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
      end else if (accept && !req_err) begin
         addr_q  <= st_addr[ADDR_W-1:2];
         wdata_q <= lane_data_d;
         be_q    <= be_d;
      end
   end

   assign mem_be = be_q;
`else
   logic        half_q;
   logic [1:0]  lane_q;
   logic [15:0] sub_q;
   logic [31:0] merged;

   // Overlay only the target lane onto the word just read back
   always_comb begin
      merged = mem_rd_data;
      if (half_q) begin
         if (lane_q[1]) merged[31:16] = sub_q;
         else           merged[15:0]  = sub_q;
      end else begin
         merged[{lane_q, 3'b000} +: 8] = sub_q[7:0];
      end
   end

   // Latch the request; the write word is either st_data or the merge result
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q  <= '0;
         wdata_q <= '0;
         half_q  <= 1'b0;
         lane_q  <= 2'b00;
         sub_q   <= '0;
      end else if (accept && !req_err) begin
         addr_q  <= st_addr[ADDR_W-1:2];
         wdata_q <= st_data;
         half_q  <= (st_type == 2'd1);
         lane_q  <= st_addr[1:0];
         sub_q   <= st_data[15:0];
      end else if (state_q == MERGE) begin
         wdata_q <= merged;
      end
   end
`endif

   // All outputs are state-decoded or registered (Moore)
   assign st_ready    = (state_q == IDLE);
   assign mem_rd_en   = (state_q == READ);
   assign mem_wr_en   = (state_q == WRITE);
   assign st_done     = (state_q == WRITE) || (state_q == ERR);
   assign st_err      = (state_q == ERR);
   assign mem_addr    = addr_q;
   assign mem_wr_data = wdata_q;

endmodule

// File: tb/tb_store_data_align.sv
// Bench for store_data_align (default RMW build). A request-level model
// schedules the expected per-cycle outputs; one compare process checks them.
module tb_store_data_align;
   localparam int ADDR_W = 32;
   localparam int NC     = 512;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        st_valid = 1'b0;
   logic [31:0] st_addr = '0;
   logic [31:0] st_data = '0;
   logic [1:0]  st_type = '0;
   logic        st_ready, st_done, st_err, mem_rd_en, mem_wr_en;
   logic [29:0] mem_addr;
   logic [31:0] mem_wr_data;
   logic [31:0] rd_q = '0;

   logic [31:0] mem [16];
   logic        poke_en = 1'b0;
   logic [3:0]  poke_a = '0;
   logic [31:0] poke_d = '0;

   int cyc = 0;
   int n_chk = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   logic        e_rdy [NC];
   logic        e_rd  [NC];
   logic        e_wr  [NC];
   logic        e_done[NC];
   logic        e_err [NC];
   logic [29:0] e_addr[NC];
   logic [31:0] e_wd  [NC];

   always #5 clk = ~clk;

   store_data_align #(.ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst_n(rst_n), .st_valid(st_valid), .st_ready(st_ready),
      .st_addr(st_addr), .st_data(st_data), .st_type(st_type),
      .st_done(st_done), .st_err(st_err), .mem_addr(mem_addr),
      .mem_rd_en(mem_rd_en), .mem_rd_data(rd_q), .mem_wr_en(mem_wr_en),
      .mem_wr_data(mem_wr_data)
   );

   // Synchronous-read memory without byte enables, plus a bench preload port
   always @(posedge clk) begin
      if (mem_rd_en) rd_q <= mem[mem_addr[3:0]];
      if (mem_wr_en) mem[mem_addr[3:0]] <= mem_wr_data;
      else if (poke_en) mem[poke_a] <= poke_d;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_chk++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, expv);
      end
   endtask

   // Per-cycle comparison against the scheduled expectations
   always @(negedge clk) begin
      if (chk_en && cyc < NC) begin
         chk("st_ready",  32'(st_ready),  32'(e_rdy[cyc]));
         chk("mem_rd_en", 32'(mem_rd_en), 32'(e_rd[cyc]));
         chk("mem_wr_en", 32'(mem_wr_en), 32'(e_wr[cyc]));
         chk("st_done",   32'(st_done),   32'(e_done[cyc]));
         chk("st_err",    32'(st_err),    32'(e_err[cyc]));
         if (e_rd[cyc] || e_wr[cyc]) chk("mem_addr", 32'(mem_addr), 32'(e_addr[cyc]));
         if (e_wr[cyc]) chk("mem_wr_data", mem_wr_data, e_wd[cyc]);
      end
   end

   // Drive one request at a negedge and schedule what it must produce
   task automatic start(input logic [31:0] a, input logic [31:0] d, input logic [1:0] t,
                        input bit pre, input logic [31:0] pv, output int k, output int len);
      logic        err;
      logic [31:0] old, mask;
      int          sh;
      k = cyc;
      st_valid = 1'b1; st_addr = a; st_data = d; st_type = t;
      if (pre) begin poke_en = 1'b1; poke_a = a[5:2]; poke_d = pv; end
      old = pre ? pv : mem[a[5:2]];
      err = (t == 2'd3) || (t == 2'd1 && a[0]) || (t == 2'd0 && a[1:0] != 2'b00);
      if (err) begin
         len = 1;
         e_rdy[k+1] = 1'b0; e_done[k+1] = 1'b1; e_err[k+1] = 1'b1;
      end else if (t == 2'd0) begin
         len = 1;
         e_rdy[k+1] = 1'b0; e_wr[k+1] = 1'b1; e_done[k+1] = 1'b1;
         e_addr[k+1] = a[31:2]; e_wd[k+1] = d;
      end else begin
         len = 3;
         for (int i = 1; i <= 3; i++) e_rdy[k+i] = 1'b0;
         e_rd[k+1] = 1'b1; e_addr[k+1] = a[31:2];
         sh   = (t == 2'd2) ? 8 * int'(a[1:0]) : 16 * int'(a[1]);
         mask = ((t == 2'd2) ? 32'h0000_00FF : 32'h0000_FFFF) << sh;
         e_wr[k+3] = 1'b1; e_done[k+3] = 1'b1; e_addr[k+3] = a[31:2];
         e_wd[k+3] = (old & ~mask) | ((d << sh) & mask);
      end
   endtask

   // Full request; junk is presented while busy and must be ignored
   task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [1:0] t,
                        input bit pre, input logic [31:0] pv);
      int k, len;
      start(a, d, t, pre, pv, k, len);
      @(negedge clk);
      poke_en = 1'b0;
      st_type = 2'd3; st_data = ~d; st_addr = a ^ 32'h4;
      repeat (len) @(negedge clk);
      st_valid = 1'b0;
   endtask

   initial begin
      int k, len;
      for (int i = 0; i < NC; i++) begin
         e_rdy[i] = 1'b1; e_rd[i] = 1'b0; e_wr[i] = 1'b0;
         e_done[i] = 1'b0; e_err[i] = 1'b0; e_addr[i] = '0; e_wd[i] = '0;
      end
      repeat (2) @(negedge clk);
      chk("rst st_ready",    32'(st_ready),    32'd1);
      chk("rst st_done",     32'(st_done),     32'd0);
      chk("rst st_err",      32'(st_err),      32'd0);
      chk("rst mem_rd_en",   32'(mem_rd_en),   32'd0);
      chk("rst mem_wr_en",   32'(mem_wr_en),   32'd0);
      chk("rst mem_addr",    32'(mem_addr),    32'd0);
      chk("rst mem_wr_data", mem_wr_data,      32'd0);
      #2 rst_n = 1'b1;
      @(negedge clk);
      chk_en = 1'b1;

      // Word store, then sub-word stores into every lane kind
      issue(32'h10, 32'hDEADBEEF, 2'd0, 1'b1, 32'h0);
      chk("mem4 sw", mem[4], 32'hDEADBEEF);
      issue(32'h12, 32'h000000AB, 2'd2, 1'b1, 32'h11223344);
      chk("mem4 sb", mem[4], 32'h11AB3344);
      issue(32'h12, 32'h0000BEEF, 2'd1, 1'b1, 32'h11223344);
      chk("mem4 sh hi", mem[4], 32'hBEEF3344);
      issue(32'h10, 32'h0000CAFE, 2'd1, 1'b1, 32'h11223344);
      chk("mem4 sh lo", mem[4], 32'h1122CAFE);
      issue(32'h23, 32'hFFFFFF5A, 2'd2, 1'b1, 32'hFFFFFFFF);
      chk("mem8 sb lane3", mem[8], 32'h5AFFFFFF);
      issue(32'h20, 32'h00000000, 2'd2, 1'b1, 32'hFFFFFFFF);
      issue(32'h21, 32'h12345677, 2'd2, 1'b0, 32'h0);
      chk("mem8 sb lane0+1", mem[8], 32'hFFFF7700);

      // Rejected requests: no strobes, memory untouched
      issue(32'h13, 32'h0000AAAA, 2'd1, 1'b0, 32'h0);
      issue(32'h11, 32'h55555555, 2'd0, 1'b0, 32'h0);
      issue(32'h12, 32'h66666666, 2'd0, 1'b0, 32'h0);
      issue(32'h10, 32'h77777777, 2'd3, 1'b0, 32'h0);
      chk("mem4 after errs", mem[4], 32'h1122CAFE);
      issue(32'h13, 32'h00000099, 2'd2, 1'b0, 32'h0);
      chk("mem4 sb lane3", mem[4], 32'h9922CAFE);

      // Reset while in READ: abort with no write and no done
      start(32'h12, 32'h000000AB, 2'd2, 1'b1, 32'h11223344, k, len);
      @(negedge clk);
      poke_en = 1'b0; st_valid = 1'b0;
      for (int i = 2; i <= 3; i++) begin
         e_rdy[k+i] = 1'b1; e_wr[k+i] = 1'b0; e_done[k+i] = 1'b0;
      end
      #2 rst_n = 1'b0;
      #1;
      chk("abort st_ready",    32'(st_ready),  32'd1);
      chk("abort mem_rd_en",   32'(mem_rd_en), 32'd0);
      chk("abort mem_addr",    32'(mem_addr),  32'd0);
      chk("abort mem_wr_data", mem_wr_data,    32'd0);
      chk("abort st_done",     32'(st_done),   32'd0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      chk("mem4 after abort", mem[4], 32'h11223344);
      issue(32'h14, 32'h12345678, 2'd0, 1'b0, 32'h0);
      chk("mem5 sw after abort", mem[5], 32'h12345678);

      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/store_data_align.md
Name: store_data_align

Overview:
- Store-side counterpart of the load sign-extension path: takes a CPU store request (sw/sh/sb) and turns it into word-wide writes to a data memory that has no byte enables.
- Sub-word stores use a read-modify-write sequence; word stores write directly; misaligned or reserved requests are rejected.
- Sits between the datapath store-issue point and the data memory port; a multi-cycle store stalls the pipeline via st_ready.

Parameters:
- ADDR_W, 32, byte address width; mem_addr is ADDR_W-2 bits (word address).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- st_valid  in  1  store request valid
- st_ready  out  1  block idle, can accept a request
- st_addr  in  ADDR_W  byte address
- st_data  in  32  store data; sub-word data is in the low bits
- st_type  in  2  0=word, 1=half, 2=byte, 3=reserved (same encoding as the load path)
- st_done  out  1  one-cycle completion pulse
- st_err  out  1  qualifies st_done: request rejected, no memory write
- mem_addr  out  ADDR_W-2  word address
- mem_rd_en  out  1  synchronous read strobe; data arrives on mem_rd_data the next cycle
- mem_rd_data  in  32  read data
- mem_wr_en  out  1  write strobe
- mem_wr_data  out  32  write data

Behaviour:
- Clocking and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values: state=IDLE; st_ready=1; st_done, st_err, mem_rd_en, mem_wr_en = 0; mem_addr=0; mem_wr_data=0.
- Byte ordering: little-endian.
  - Byte lane = addr[1:0], bits [8*lane+7 : 8*lane].
  - Half lane = addr[1], bits [16*addr[1]+15 : 16*addr[1]].
- Request latch: accept on st_valid & st_ready (IDLE only). At acceptance, latch addr, data and type.
- Error checks, made at acceptance:
  - Half store with addr[0]=1 → ERR.
  - Word store with addr[1:0]!=0 → ERR.
  - type=3 → ERR.
- FSM states: IDLE, READ, MERGE, WRITE, ERR.
  - IDLE: on accept → WRITE (word), READ (half/byte), or ERR.
  - READ: mem_rd_en=1, mem_addr=addr[ADDR_W-1:2]. → MERGE.
  - MERGE: capture mem_rd_data and replace only the target lane with st_data[7:0] or st_data[15:0]; all other bits unchanged. → WRITE.
  - WRITE: mem_wr_en=1, mem_addr=latched word address, mem_wr_data=merged word (word store: latched data). st_done=1. → IDLE.
  - ERR: st_done=1, st_err=1, no memory strobes. → IDLE.
- Output style: all outputs are Moore (state-decoded or registered). st_ready=1 only in IDLE. Strobes are exactly one cycle wide.
- Latency, with acceptance at edge k:
  - Word: WRITE/st_done in cycle k+1, st_ready back in k+2.
  - Sub-word: READ in k+1, MERGE in k+2, WRITE/st_done in k+3.
  - Error: ERR/st_done in k+1.
- st_valid while busy is ignored; the requester must hold the request until st_ready.
- Back-to-back requests: a new request is accepted in the first IDLE cycle after done; no bypass, so each RMW completes before the next read.
- Reset mid-operation: abort immediately to IDLE. No write is issued and st_done is not pulsed for the aborted request.
- mem_addr holds its last value outside READ/WRITE.

Optional Feature:
- Macro: STORE_BE_EN.
- When defined:
  - Adds output port mem_be [3:0].
  - Sub-word stores skip READ/MERGE and go IDLE→WRITE, same latency as a word store.
  - mem_wr_data = data shifted into its lane, other bits 0.
  - mem_be: 4'b1111 for word; 4'b0011 or 4'b1100 for half; one-hot on addr[1:0] for byte.
  - mem_rd_en is never asserted.
- When not defined: no mem_be port; RMW behaviour as above.
- Error handling is identical in both builds.

Test Plan:
- sw 0xDEADBEEF @0x10, mem[4]=0 → one mem_wr_en at word 4, data 0xDEADBEEF, st_done in k+1, no read, st_err=0.
- sb 0xAB @0x12, mem[4]=0x11223344 → read word 4, write 0x11AB3344, st_done in k+3.
- sh 0xBEEF @0x12, mem[4]=0x11223344 → write 0xBEEF3344; sh 0xCAFE @0x10 → write 0x1122CAFE.
- sh @0x13, then sw @0x11, then type=3 → each gives st_done=1, st_err=1 in k+1, zero mem strobes.
- sb @0x12 with rst_n pulled low in READ → outputs at reset values, no mem_wr_en, no st_done; the next sw completes normally.
- STORE_BE_EN build: sb 0xAB @0x11 → mem_be=4'b0010, mem_wr_data=0x0000AB00, no read, st_done in k+1.
